// File: rtl/tqv_spi_reg_initiator.sv
// SPI mode-0 register initiator that turns one parallel command into one frame for the TinyQV responder.
// Optional macro WAIT_READY_EN: reads wait on a synchronised data_ready_in (with timeout) instead of a fixed gap.

module tqv_spi_reg_initiator #(
  parameter int CLK_DIV   = 4,
  parameter int READ_WAIT = 8,
  parameter int TMO_CYC   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [1:0]  cmd_width,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        data_ready_in
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_CS_HOLD  = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;

  localparam int WAIT_CYC = READ_WAIT * 2 * CLK_DIV;
  localparam int MAX_A    = (WAIT_CYC > TMO_CYC) ? WAIT_CYC : TMO_CYC;
  localparam int CNT_MAX  = (MAX_A > 2 * CLK_DIV) ? MAX_A : 2 * CLK_DIV;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(2 * CLK_DIV - 1);
`ifdef WAIT_READY_EN
  localparam logic [CW-1:0] WAIT_LD = CW'(TMO_CYC - 1);
`else
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYC - 1);
`endif

  function automatic logic [5:0] width_bits(input logic [1:0] w);
    case (w)
      2'b00:   return 6'd8;
      2'b01:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Left-justify the payload so the shifter always emits from bit 47.
  function automatic logic [31:0] align_msb(input logic [31:0] d, input logic [1:0] w);
    case (w)
      2'b00:   return {d[7:0], 24'h0};
      2'b01:   return {d[15:0], 16'h0};
      default: return d;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic [47:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [5:0]    bits_q, bits_d;
  logic [5:0]    nbits_q, nbits_d;
  logic          rw_q, rw_d;
  logic          tmo_q, tmo_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

`ifdef WAIT_READY_EN
  logic rdy_meta_q, rdy_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      rdy_meta_q <= data_ready_in;
      rdy_sync_q <= rdy_meta_q;
    end
  end
`else
  logic unused_data_ready;
  assign unused_data_ready = data_ready_in;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bits_d      = bits_q;
    nbits_d     = nbits_q;
    rw_d        = rw_q;
    tmo_d       = tmo_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rw_d    = cmd_rw;
          nbits_d = width_bits(cmd_width);
          tx_d    = {cmd_rw, 5'b0, cmd_width, 2'b00, cmd_addr,
                     cmd_rw ? align_msb(cmd_wdata, cmd_width) : 32'h0};
          rx_d    = '0;
          tmo_d   = 1'b0;
          cs_n_d  = 1'b0;
          cnt_d   = HALF_LD;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = HALF_LD;
          bits_d  = 6'd16;
          state_d = S_HEADER;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HEADER, S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cnt_d = HALF_LD;
          sck_d = !sck_q;
          if (!sck_q) begin
            if (state_q == S_DATA) rx_d = {rx_q[30:0], spi_miso};
          end else begin
            // Falling edge: advance MOSI and retire one bit of the current phase.
            tx_d   = {tx_q[46:0], 1'b0};
            bits_d = bits_q - 6'd1;
            if (bits_q == 6'd1) begin
              if (state_q == S_DATA) begin
                state_d = S_CS_HOLD;
              end else if (rw_q) begin
                bits_d  = nbits_q;
                state_d = S_DATA;
              end else begin
                cnt_d   = WAIT_LD;
                state_d = S_WAIT;
              end
            end
          end
        end
      end

      S_WAIT: begin
`ifdef WAIT_READY_EN
        if (rdy_sync_q) begin
          bits_d  = nbits_q;
          cnt_d   = HALF_LD;
          state_d = S_DATA;
        end else if (cnt_zero) begin
          tmo_d   = 1'b1;
          cnt_d   = HALF_LD;
          state_d = S_CS_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`else
        if (cnt_zero) begin
          bits_d  = nbits_q;
          cnt_d   = HALF_LD;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end

      S_CS_HOLD: begin
        if (cnt_zero) begin
          cs_n_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_zero) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = tmo_q;
          rsp_rdata_d = (rw_q || tmo_q) ? 32'h0 : rx_q;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ready stays low during the response cycle so the next accept lands strictly after it.
    cmd_ready_d = (state_d == S_IDLE) && !rsp_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      bits_q      <= '0;
      nbits_q     <= '0;
      rw_q        <= 1'b0;
      tmo_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bits_q      <= bits_d;
      nbits_q     <= nbits_d;
      rw_q        <= rw_d;
      tmo_q       <= tmo_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  // Without WAIT_READY_EN the timeout flag is never set, so this stays 0.
  assign rsp_err   = rsp_err_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sck_q;
  assign spi_mosi  = tx_q[47];

endmodule
